pipe_stage_skid: RTL and testbench

// - Parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with valid/ready handshake and 2-entry skid buffer.
// - Adds stall back-pressure, synchronous flush, bubble control-masking and saturating stall/drop counters.
// - Sits between two pipeline stages; upstream drives in_*, downstream consumes out_*.
// - Hazard unit drives flush_i.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_skid.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers: control-bundle
// bit positions and per-stage bundle/payload widths.
package pipe_pkg;

  // Bit positions inside the control bundle {MemtoReg,RegWrite,MemRead,MemWrite,Branch}
  localparam int unsigned CTRL_BRANCH   = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMREAD  = 2;
  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMTOREG = 4;

  localparam int unsigned IDEX_CTRL_W  = 5;
  localparam int unsigned IDEX_DATA_W  = 101;
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned EXMEM_DATA_W = 101;
  localparam int unsigned MEMWB_CTRL_W = 2;
  localparam int unsigned MEMWB_DATA_W = 69;

  localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} storage slot with load / clear / hold control.
// Load wins over clear; clear only drops the valid bit, payload is kept.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush, bubble control masking and saturating counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W      = EXMEM_CTRL_W,
  parameter int unsigned DATA_W      = EXMEM_DATA_W,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter bit          MASK_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int unsigned         SUM_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0]    CNT_MAX = '1;

  logic              head_valid, skid_valid;
  logic [CTRL_W-1:0] head_ctrl,  skid_ctrl;
  logic [DATA_W-1:0] head_data,  skid_data;

  logic              head_load, head_clear, head_from_skid;
  logic              skid_load, skid_clear;
  logic [CTRL_W-1:0] head_ctrl_in;
  logic [DATA_W-1:0] head_data_in;

  logic              acc, pop;

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic              stall_inc;
  logic [1:0]        drop_inc;
  logic [SUM_W-1:0]  stall_sum, drop_sum;

  // Ready comes straight off the skid valid register
  assign in_ready_o = !skid_valid;
  assign acc        = in_valid_i & !skid_valid;
  assign pop        = head_valid & out_ready_i;

  // Slot control; skid is only ever occupied while head is occupied
  always_comb begin
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_i) begin
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (!head_valid) begin
      head_load = acc;
    end else if (pop) begin
      if (skid_valid) begin
        head_load      = 1'b1;
        head_from_skid = 1'b1;
        skid_clear     = 1'b1;
      end else if (acc) begin
        head_load = 1'b1;
      end else begin
        head_clear = 1'b1;
      end
    end else begin
      skid_load = acc;
    end
  end

  assign head_ctrl_in = head_from_skid ? skid_ctrl : in_ctrl_i;
  assign head_data_in = head_from_skid ? skid_data : in_data_i;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_head (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (head_load),
    .clear_i (head_clear),
    .ctrl_i  (head_ctrl_in),
    .data_i  (head_data_in),
    .valid_o (head_valid),
    .ctrl_o  (head_ctrl),
    .data_o  (head_data)
  );

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .ctrl_i  (in_ctrl_i),
    .data_i  (in_data_i),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  // Saturating counters; adders are two bits wider so the compare never wraps
  always_comb begin
    stall_inc = head_valid & !out_ready_i & !flush_i;
    drop_inc  = 2'b00;
    if (flush_i) begin
      drop_inc = 2'(head_valid & !pop) + 2'(skid_valid) + 2'(acc);
    end
    stall_sum   = SUM_W'(stall_cnt_q) + SUM_W'(stall_inc);
    drop_sum    = SUM_W'(drop_cnt_q) + SUM_W'(drop_inc);
    stall_cnt_d = (stall_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : stall_sum[CNT_W-1:0];
    drop_cnt_d  = (drop_sum  > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid_o = head_valid;
  assign out_ctrl_o  = (MASK_BUBBLE && !head_valid) ? '0 : head_ctrl;
  assign out_data_o  = head_data;
  assign stall_cnt_o = stall_cnt_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a default instance plus a CNT_W=2,
// unmasked instance sharing the same stimulus.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 101;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt, drop_cnt;

  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_stall_cnt, s_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16), .MASK_BUBBLE(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ctrl_o(out_ctrl), .out_data_o(out_data),
    .stall_cnt_o(stall_cnt), .drop_cnt_o(drop_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(2), .MASK_BUBBLE(1'b0)) u_sat (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_ctrl_o(s_out_ctrl), .out_data_o(s_out_data),
    .stall_cnt_o(s_stall_cnt), .drop_cnt_o(s_drop_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 5'h1F, 101'hAA);

    // Reset with a valid beat pending on the input
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
    chk("rst_out_data",  128'(out_data),  128'd0);
    chk("rst_in_ready",  128'(in_ready),  128'd1);
    chk("rst_stall",     128'(stall_cnt), 128'd0);
    chk("rst_drop",      128'(drop_cnt),  128'd0);
    rst = 1'b0;

    // Streaming at one beat per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 101'(i));
      tick();
      chk("stream_valid", 128'(out_valid), 128'd1);
      chk("stream_data",  128'(out_data),  128'(i));
      chk("stream_ready", 128'(in_ready),  128'd1);
    end
    drive(1'b0, 5'h00, 101'h0);
    tick();
    chk("stream_drain_valid", 128'(out_valid),   128'd0);
    chk("bubble_mask_ctrl",   128'(out_ctrl),    128'd0);
    chk("bubble_raw_ctrl",    128'(s_out_ctrl),  128'h08);
    chk("stream_stall",       128'(stall_cnt),   128'd0);
    chk("stream_sat_valid",   128'(s_out_valid), 128'd0);

    // Back-pressure: two beats fit, third is refused
    out_ready = 1'b0;
    drive(1'b1, 5'h03, 101'h11);
    tick();
    chk("bp_ready_1", 128'(in_ready), 128'd1);
    drive(1'b1, 5'h05, 101'h22);
    tick();
    chk("bp_ready_full", 128'(in_ready),   128'd0);
    chk("bp_sat_ready",  128'(s_in_ready), 128'd0);
    drive(1'b1, 5'h07, 101'h33);
    tick(); tick();
    chk("bp_stall3",     128'(stall_cnt), 128'd3);
    chk("bp_head_data",  128'(out_data),  128'h11);
    chk("bp_head_ctrl",  128'(out_ctrl),  128'h03);
    chk("bp_still_full", 128'(in_ready),  128'd0);
    drive(1'b0, 5'h00, 101'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_data",  128'(out_data),   128'h22);
    chk("bp_rel_ctrl",  128'(out_ctrl),   128'h05);
    chk("bp_rel_ready", 128'(in_ready),   128'd1);
    chk("bp_rel_sdata", 128'(s_out_data), 128'h22);
    chk("bp_rel_stall", 128'(stall_cnt),  128'd3);
    tick();
    chk("bp_empty", 128'(out_valid), 128'd0);

    // Flush with both slots full; input beat cannot be accepted so two drops
    out_ready = 1'b0;
    drive(1'b1, 5'(1 << CTRL_MEMWRITE), 101'hA1);
    tick();
    drive(1'b1, 5'(1 << CTRL_REGWRITE), 101'hA2);
    tick();
    chk("ff_full", 128'(in_ready), 128'd0);
    drive(1'b1, 5'h1F, 101'hA3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ff_valid", 128'(out_valid), 128'd0);
    chk("ff_ready", 128'(in_ready),  128'd1);
    chk("ff_drop",  128'(drop_cnt),  128'd2);
    chk("ff_stall", 128'(stall_cnt), 128'd4);

    // Flush with head valid and an accepted input beat: head + input dropped
    drive(1'b1, 5'h01, 101'hB1);
    tick();
    drive(1'b1, 5'h02, 101'hB2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fa_valid", 128'(out_valid), 128'd0);
    chk("fa_drop",  128'(drop_cnt),  128'd4);
    chk("fa_stall", 128'(stall_cnt), 128'd4);

    // Flush coinciding with a pop: head consumed, not counted
    drive(1'b1, 5'(1 << CTRL_MEMREAD), 101'hC1);
    tick();
    drive(1'b0, 5'h00, 101'h0);
    out_ready = 1'b1;
    flush = 1'b1;
    chk("fp_pre_valid", 128'(out_valid), 128'd1);
    chk("fp_pre_data",  128'(out_data),  128'hC1);
    tick();
    flush = 1'b0;
    chk("fp_valid",    128'(out_valid), 128'd0);
    chk("fp_drop",     128'(drop_cnt),  128'd4);
    chk("fp_raw_data", 128'(out_data),  128'hC1);

    // Reset mid-operation, then saturate the narrow stall counter
    out_ready = 1'b0;
    drive(1'b1, 5'h09, 101'hD0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 128'(out_valid),  128'd0);
    chk("mid_rst_drop",  128'(drop_cnt),   128'd0);
    chk("mid_rst_sdrop", 128'(s_drop_cnt), 128'd0);
    drive(1'b1, 5'h09, 101'hD1);
    tick();
    drive(1'b0, 5'h00, 101'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_stall_wide",   128'(stall_cnt),   128'd5);
    chk("sat_stall_narrow", 128'(s_stall_cnt), 128'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_drop_wide",   128'(drop_cnt),    128'd1);
    chk("sat_drop_narrow", 128'(s_drop_cnt),  128'd1);
    chk("sat_stall_hold",  128'(s_stall_cnt), 128'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
